// File: rtl/cpu_pkg.sv
// Shared definitions for the execute-stage ALU core: width, opcodes, flag bundle.
package cpu_pkg;

  localparam int unsigned WIDTH = 8;

  localparam logic [7:0] OP_AND   = 8'h00;
  localparam logic [7:0] OP_OR    = 8'h01;
  localparam logic [7:0] OP_XOR   = 8'h02;
  localparam logic [7:0] OP_NOT   = 8'h03;
  localparam logic [7:0] OP_ADD   = 8'h04;
  localparam logic [7:0] OP_SUB   = 8'h05;
  localparam logic [7:0] OP_ADC   = 8'h06;
  localparam logic [7:0] OP_SBB   = 8'h07;
  localparam logic [7:0] OP_INC   = 8'h08;
  localparam logic [7:0] OP_DEC   = 8'h09;
  localparam logic [7:0] OP_SHL   = 8'h0A;
  localparam logic [7:0] OP_SHR   = 8'h0B;
  localparam logic [7:0] OP_ASR   = 8'h0C;
  localparam logic [7:0] OP_ROL   = 8'h0D;
  localparam logic [7:0] OP_ROR   = 8'h0E;
  localparam logic [7:0] OP_CMP   = 8'h0F;
  localparam logic [7:0] OP_PASSB = 8'h10;

  typedef struct packed {
    logic zero;
    logic carry;
    logic negative;
  } flags_t;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: next result, next flags and result write-enable (low for CMP).
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = cpu_pkg::WIDTH
) (
  input  logic [7:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] next_result,
  output flags_t           next_flags,
  output logic             result_we
);

  logic [WIDTH:0]   wide;
  logic [WIDTH-1:0] res;
  logic             cout;

  // Operation select; res is also the flag source (CMP's difference is simply not written back).
  always_comb begin
    wide      = '0;
    res       = '0;
    cout      = 1'b0;
    result_we = 1'b1;
    case (opcode)
      OP_AND:   res = a & b;
      OP_OR:    res = a | b;
      OP_XOR:   res = a ^ b;
      OP_NOT:   res = ~a;
      OP_ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        res  = wide[WIDTH-1:0];
        cout = wide[WIDTH];
      end
      OP_SUB, OP_CMP: begin
        wide      = {1'b0, a} - {1'b0, b};
        res       = wide[WIDTH-1:0];
        cout      = wide[WIDTH];
        result_we = (opcode != OP_CMP);
      end
      OP_ADC: begin
        wide = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};
        res  = wide[WIDTH-1:0];
        cout = wide[WIDTH];
      end
      OP_SBB: begin
        wide = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, carry_in};
        res  = wide[WIDTH-1:0];
        cout = wide[WIDTH];
      end
      OP_INC: begin
        res  = a + {{(WIDTH-1){1'b0}}, 1'b1};
        cout = (a == '1);
      end
      OP_DEC: begin
        res  = a - {{(WIDTH-1){1'b0}}, 1'b1};
        cout = (a == '0);
      end
      OP_SHL: begin
        res  = {a[WIDTH-2:0], 1'b0};
        cout = a[WIDTH-1];
      end
      OP_SHR: begin
        res  = {1'b0, a[WIDTH-1:1]};
        cout = a[0];
      end
      OP_ASR: begin
        res  = {a[WIDTH-1], a[WIDTH-1:1]};
        cout = a[0];
      end
      OP_ROL: begin
        res  = {a[WIDTH-2:0], a[WIDTH-1]};
        cout = a[WIDTH-1];
      end
      OP_ROR: begin
        res  = {a[0], a[WIDTH-1:1]};
        cout = a[0];
      end
      OP_PASSB: res = b;
      default:  res = '0;
    endcase
    next_result         = res;
    next_flags.zero     = (res == '0);
    next_flags.carry    = cout;
    next_flags.negative = res[WIDTH-1];
  end

endmodule

// File: rtl/cpu.sv
// Execute-stage core: registers ALU result and flags, synchronous reset.
module cpu
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = cpu_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       opcode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             negative
);

  logic [WIDTH-1:0] result_q, result_d, alu_result;
  flags_t           flags_q, flags_d, alu_flags;
  logic             alu_we;

  cpu_alu #(.WIDTH(WIDTH)) u_alu (
    .opcode      (opcode),
    .a           (A),
    .b           (B),
    .carry_in    (flags_q.carry),
    .next_result (alu_result),
    .next_flags  (alu_flags),
    .result_we   (alu_we)
  );

  // Next state: result holds when the op does not write it back.
  always_comb begin
    result_d = alu_we ? alu_result : result_q;
    flags_d  = alu_flags;
  end

  // Output registers; reset overrides any presented op.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign result   = result_q;
  assign zero     = flags_q.zero;
  assign carry    = flags_q.carry;
  assign negative = flags_q.negative;

endmodule

// File: tb/tb_cpu.sv
// Bench for cpu: integer-arithmetic reference model checked every cycle, plus literal spot checks.
module tb_cpu;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] opcode = 8'h00;
  logic [7:0] A = 8'h00;
  logic [7:0] B = 8'h00;
  logic [7:0] result;
  logic       zero, carry, negative;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_res = 0;
  int m_z = 0;
  int m_c = 0;
  int m_n = 0;

  cpu #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .opcode   (opcode),
    .A        (A),
    .B        (B),
    .result   (result),
    .zero     (zero),
    .carry    (carry),
    .negative (negative)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: update on each edge from the spec's arithmetic rules, compare 1 unit later.
  always @(posedge clk) begin
    int ia, ib, v;
    bit cf, wr;
    ia = int'(A);
    ib = int'(B);
    wr = 1'b1;
    cf = 1'b0;
    v  = 0;
    if (rst) begin
      m_res = 0; m_z = 0; m_c = 0; m_n = 0;
    end else begin
      case (int'(opcode))
        0:  v = ia & ib;
        1:  v = ia | ib;
        2:  v = ia ^ ib;
        3:  v = 255 - ia;
        4:  begin v = ia + ib; cf = (v > 255); end
        5:  begin v = ia - ib; cf = (ia < ib); end
        6:  begin v = ia + ib + m_c; cf = (v > 255); end
        7:  begin v = ia - ib - m_c; cf = (ia < ib + m_c); end
        8:  begin v = ia + 1; cf = (ia == 255); end
        9:  begin v = ia - 1; cf = (ia == 0); end
        10: begin v = ia * 2; cf = (ia >= 128); end
        11: begin v = ia / 2; cf = ((ia % 2) == 1); end
        12: begin v = ia / 2 + ((ia >= 128) ? 128 : 0); cf = ((ia % 2) == 1); end
        13: begin v = ia * 2 + ia / 128; cf = (ia >= 128); end
        14: begin v = ia / 2 + (ia % 2) * 128; cf = ((ia % 2) == 1); end
        15: begin v = ia - ib; cf = (ia < ib); wr = 1'b0; end
        16: v = ib;
        default: v = 0;
      endcase
      v = ((v % 256) + 256) % 256;
      m_z = (v == 0) ? 1 : 0;
      m_n = (v >= 128) ? 1 : 0;
      m_c = cf ? 1 : 0;
      if (wr) m_res = v;
    end
    #1;
    chk("model_result",   int'(result),   m_res);
    chk("model_zero",     int'(zero),     m_z);
    chk("model_carry",    int'(carry),    m_c);
    chk("model_negative", int'(negative), m_n);
  end

  task automatic op(input logic [7:0] o, input logic [7:0] a, input logic [7:0] b, input logic r = 1'b0);
    @(negedge clk);
    rst = r; opcode = o; A = a; B = b;
    @(posedge clk);
    #2;
  endtask

  task automatic lit(input string name, input int r, input int z, input int c, input int n);
    chk({name, "_result"},   int'(result),   r);
    chk({name, "_zero"},     int'(zero),     z);
    chk({name, "_carry"},    int'(carry),    c);
    chk({name, "_negative"}, int'(negative), n);
  endtask

  initial begin
    op(8'h04, 8'hFF, 8'hFF, 1'b1);
    op(8'h04, 8'hFF, 8'hFF, 1'b1);
    lit("reset", 0, 0, 0, 0);

    op(8'h00, 8'hCC, 8'hAA); lit("and",  8'h88, 0, 0, 1);
    op(8'h04, 8'hFF, 8'h01); lit("add",  8'h00, 1, 1, 0);
    op(8'h06, 8'h10, 8'h20); lit("adc",  8'h31, 0, 0, 0);
    op(8'h05, 8'h05, 8'h07); lit("sub",  8'hFE, 0, 1, 1);
    op(8'h07, 8'h10, 8'h01); lit("sbb",  8'h0E, 0, 0, 0);
    op(8'h0A, 8'h81, 8'h00); lit("shl",  8'h02, 0, 1, 0);
    op(8'h0E, 8'h01, 8'h00); lit("ror",  8'h80, 0, 1, 1);
    op(8'h0C, 8'h80, 8'h00); lit("asr",  8'hC0, 0, 0, 1);
    op(8'h00, 8'hCC, 8'hAA);
    op(8'h0F, 8'h33, 8'h33); lit("cmp_eq", 8'h88, 1, 0, 0);
    op(8'h0F, 8'h01, 8'h02); lit("cmp_lt", 8'h88, 0, 1, 1);
    op(8'h42, 8'hFF, 8'hFF); lit("undef", 8'h00, 1, 0, 0);
    op(8'h04, 8'h01, 8'h01, 1'b1); lit("rst_wins", 0, 0, 0, 0);
    op(8'h04, 8'h01, 8'h01); lit("after_rst", 8'h02, 0, 0, 0);

    // carry chains and boundaries
    op(8'h04, 8'hFF, 8'hFF); lit("add_ovf", 8'hFE, 0, 1, 1);
    op(8'h06, 8'h00, 8'h00); lit("adc_cin", 8'h01, 0, 0, 0);
    op(8'h05, 8'h00, 8'h01);
    op(8'h07, 8'h05, 8'h05); lit("sbb_bin", 8'hFF, 0, 1, 1);
    op(8'h06, 8'hFF, 8'h00); lit("adc_wrap", 8'h00, 1, 1, 0);
    op(8'h08, 8'hFF, 8'h00); lit("inc_ff", 8'h00, 1, 1, 0);
    op(8'h09, 8'h00, 8'h00); lit("dec_00", 8'hFF, 0, 1, 1);

    // remaining opcodes, model-checked
    op(8'h01, 8'h0F, 8'hF0);
    op(8'h02, 8'hA5, 8'hA5);
    op(8'h03, 8'h5A, 8'h00);
    op(8'h08, 8'h7F, 8'h00);
    op(8'h09, 8'h80, 8'h00);
    op(8'h0B, 8'h81, 8'h00);
    op(8'h0C, 8'h41, 8'h00);
    op(8'h0D, 8'h80, 8'h00);
    op(8'h0D, 8'h41, 8'h00);
    op(8'h0E, 8'h02, 8'h00);
    op(8'h10, 8'h00, 8'h9C);
    op(8'h10, 8'hFF, 8'h00);
    op(8'h11, 8'h12, 8'h34);
    op(8'hFF, 8'h12, 8'h34);
    op(8'h0F, 8'h80, 8'h7F);
    op(8'h07, 8'h00, 8'hFF);
    op(8'h07, 8'h00, 8'h00);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
